// File: rtl/simd_result_collector.sv
// simd_result_collector
// Gathers one result per SIMD lane into assembly slots. When every slot is
// filled, the slots are packed into a single vector and written into a small
// first-word-fall-through FIFO that feeds writeback over valid/ready.
// A lane that finishes early is held off individually until its vector
// completes. In a push cycle the freed slots accept new results at the same
// edge, which sustains one vector per cycle.
module simd_result_collector #(
  parameter int LANES = 4,
  parameter int RES_W = 9,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic [LANES-1:0]           lane_valid,
  input  logic [LANES*RES_W-1:0]     lane_result,
  output logic [LANES-1:0]           lane_ready,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [LANES*RES_W-1:0]     out_data,
  output logic [LANES-1:0]           out_carry,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int VEC_W = LANES * RES_W;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  // Assembly slots
  logic [LANES-1:0] r_captured;
  logic [RES_W-1:0] r_slot [LANES];

  // FIFO storage and bookkeeping
  logic [VEC_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;

  logic             w_pop;
  logic             w_push;
  logic             w_all_captured;
  logic             w_has_room;
  logic [VEC_W-1:0] w_slot_vec;

  // Handshake decode: a pop frees an entry at the same edge, so a full FIFO
  // can still take a push when the head is leaving.
  always_comb begin
    out_valid      = (r_count != '0);
    w_pop          = out_valid && out_ready;
    w_all_captured = &r_captured;
    w_has_room     = (r_count < FULL_CNT) || w_pop;
    w_push         = w_all_captured && w_has_room;
    lane_ready     = ~r_captured | {LANES{w_push}};
  end

  // Pack the assembly slots in the same lane layout as lane_result.
  always_comb begin
    w_slot_vec = '0;
    for (int i = 0; i < LANES; i++) begin
      w_slot_vec[i*RES_W +: RES_W] = r_slot[i];
    end
  end

  // Head of the FIFO is shown combinationally; carry bits are the top bit of
  // each lane field and are reported without interpretation.
  always_comb begin
    out_data  = r_mem[r_rptr];
    out_carry = '0;
    for (int i = 0; i < LANES; i++) begin
      out_carry[i] = out_data[i*RES_W + RES_W - 1];
    end
    count = r_count;
  end

  // Per-lane capture: a filled slot ignores its lane until the vector is
  // pushed; a push and a new capture may coincide on the same slot.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_captured <= '0;
      for (int i = 0; i < LANES; i++) begin
        r_slot[i] <= '0;
      end
    end else if (flush) begin
      r_captured <= '0;
    end else begin
      for (int i = 0; i < LANES; i++) begin
        if (lane_valid[i] && lane_ready[i]) begin
          r_captured[i] <= 1'b1;
          r_slot[i]     <= lane_result[i*RES_W +: RES_W];
        end else if (w_push) begin
          r_captured[i] <= 1'b0;
        end
      end
    end
  end

  // FIFO storage write at the tail; flush suppresses the write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_push && !flush) begin
      r_mem[r_wptr] <= w_slot_vec;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a
  // power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PTR_ONE;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CNT_ONE;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_simd_result_collector.sv
// Bench for simd_result_collector: directed scenarios followed by random
// traffic, checked by a queue-based reference model and a scoreboard monitor.
module tb_simd_result_collector;

  localparam int LANES = 4;
  localparam int RES_W = 9;
  localparam int DEPTH = 4;
  localparam int VEC_W = LANES * RES_W;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic                 clk;
  logic                 reset;
  logic                 flush;
  logic [LANES-1:0]     lane_valid;
  logic [VEC_W-1:0]     lane_result;
  logic [LANES-1:0]     lane_ready;
  logic                 out_valid;
  logic                 out_ready;
  logic [VEC_W-1:0]     out_data;
  logic [LANES-1:0]     out_carry;
  logic [CNT_W-1:0]     count;

  int n_vec  = 0;
  int n_fail = 0;

  // Reference model: slot contents, FIFO as a queue, expected outputs queue.
  logic [LANES-1:0] m_cap;
  logic [RES_W-1:0] m_dat [LANES];
  logic [VEC_W-1:0] m_fifo [$];
  logic [VEC_W-1:0] exp_q  [$];
  logic             m_pop;
  logic             m_push;
  logic [LANES-1:0] m_rdy;
  logic [VEC_W-1:0] m_vec;

  simd_result_collector #(.LANES(LANES), .RES_W(RES_W), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .lane_valid  (lane_valid),
    .lane_result (lane_result),
    .lane_ready  (lane_ready),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_carry   (out_carry),
    .count       (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [LANES-1:0] carry_of(input logic [VEC_W-1:0] v);
    logic [LANES-1:0] c;
    for (int i = 0; i < LANES; i++) c[i] = v[i*RES_W + RES_W - 1];
    return c;
  endfunction

  function automatic logic [VEC_W-1:0] pack4(input logic [RES_W-1:0] l0, input logic [RES_W-1:0] l1,
                                              input logic [RES_W-1:0] l2, input logic [RES_W-1:0] l3);
    return {l3, l2, l1, l0};
  endfunction

  function automatic logic [VEC_W-1:0] rand_vec();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[VEC_W-1:0];
  endfunction

  // Apply one cycle of inputs, return just after the following rising edge.
  task automatic step(input logic [LANES-1:0] v, input logic [VEC_W-1:0] res,
                      input logic ordy, input logic fl);
    lane_valid  = v;
    lane_result = res;
    out_ready   = ordy;
    flush       = fl;
    @(posedge clk);
    #1;
  endtask

  // Reference model: evaluates the handshake from the rules, checks the
  // DUT's control outputs, then advances its own state as the edge would.
  always @(negedge clk) begin
    if (!reset) begin
      m_cap = '0;
      m_fifo.delete();
      exp_q.delete();
    end else begin
      m_pop  = (m_fifo.size() != 0) && out_ready;
      m_push = (&m_cap) && ((m_fifo.size() < DEPTH) || m_pop);
      m_rdy  = ~m_cap | {LANES{m_push}};
      chk("lane_ready", 64'(lane_ready), 64'(m_rdy));
      chk("out_valid", 64'(out_valid), 64'(m_fifo.size() != 0));
      chk("count", 64'(count), 64'(m_fifo.size()));
      if (flush) begin
        m_cap = '0;
        m_fifo.delete();
        exp_q.delete();
      end else begin
        if (m_pop) void'(m_fifo.pop_front());
        if (m_push) begin
          for (int i = 0; i < LANES; i++) m_vec[i*RES_W +: RES_W] = m_dat[i];
          m_fifo.push_back(m_vec);
          exp_q.push_back(m_vec);
          m_cap = '0;
        end
        for (int i = 0; i < LANES; i++) begin
          if (lane_valid[i] && m_rdy[i]) begin
            m_cap[i] = 1'b1;
            m_dat[i] = lane_result[i*RES_W +: RES_W];
          end
        end
      end
    end
  end

  // Scoreboard monitor: every accepted head vector must match the oldest
  // expected vector.
  always @(negedge clk) begin
    if (reset && out_valid && out_ready && !flush) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL unexpected_pop: got %0h expected no vector", out_data);
      end else begin
        chk("out_data", 64'(out_data), 64'(exp_q[0]));
        chk("out_carry", 64'(out_carry), 64'(carry_of(exp_q[0])));
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    reset       = 1'b0;
    flush       = 1'b0;
    lane_valid  = '0;
    lane_result = '0;
    out_ready   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_lane_ready", 64'(lane_ready), 64'hF);
    chk("rst_out_valid", 64'(out_valid), 64'h0);
    chk("rst_out_data", 64'(out_data), 64'h0);
    chk("rst_out_carry", 64'(out_carry), 64'h0);
    chk("rst_count", 64'(count), 64'h0);
    reset = 1'b1;
    step('0, '0, 1'b0, 1'b0);

    // Basic capture and packing
    step(4'hF, pack4(9'h005, 9'h1FF, 9'h0A0, 9'h100), 1'b0, 1'b0);
    step('0, '0, 1'b0, 1'b0);
    chk("basic_valid", 64'(out_valid), 64'h1);
    chk("basic_data", 64'(out_data), 64'(pack4(9'h005, 9'h1FF, 9'h0A0, 9'h100)));
    chk("basic_carry", 64'(out_carry), 64'hA);
    chk("basic_count", 64'(count), 64'h1);
    step('0, '0, 1'b1, 1'b0);
    step('0, '0, 1'b0, 1'b0);

    // Staggered lanes, lane 0 held after its first result
    step(4'h1, pack4(9'h011, 9'h0, 9'h0, 9'h0), 1'b0, 1'b0);
    chk("stag_ready0_c2", 64'(lane_ready[0]), 64'h0);
    step(4'h1, pack4(9'h022, 9'h0, 9'h0, 9'h0), 1'b0, 1'b0);
    step(4'h1, pack4(9'h022, 9'h0, 9'h0, 9'h0), 1'b0, 1'b0);
    chk("stag_ready0_c4", 64'(lane_ready[0]), 64'h0);
    step(4'hF, pack4(9'h022, 9'h033, 9'h033, 9'h033), 1'b0, 1'b0);
    step('0, '0, 1'b0, 1'b0);
    chk("stag_data", 64'(out_data), 64'(pack4(9'h011, 9'h033, 9'h033, 9'h033)));
    step('0, '0, 1'b1, 1'b0);
    step('0, '0, 1'b0, 1'b0);

    // Full FIFO: five vectors offered with no drain
    for (int k = 0; k < 5; k++) step(4'hF, rand_vec(), 1'b0, 1'b0);
    chk("full_count", 64'(count), 64'h4);
    chk("full_ready", 64'(lane_ready), 64'h0);
    step('0, '0, 1'b1, 1'b0);
    chk("full_swap_count", 64'(count), 64'h4);
    repeat (5) step('0, '0, 1'b1, 1'b0);
    chk("full_drained", 64'(count), 64'h0);

    // Streaming one vector per cycle
    for (int k = 0; k < 20; k++) begin
      step(4'hF, pack4(RES_W'(4*k), RES_W'(4*k+1), RES_W'(4*k+2), RES_W'(4*k+3)), 1'b1, 1'b0);
      if (k >= 2) chk("stream_count", 64'(count), 64'h1);
    end
    repeat (3) step('0, '0, 1'b1, 1'b0);

    // Flush with partial vector and three queued vectors
    for (int k = 0; k < 3; k++) step(4'hF, rand_vec(), 1'b0, 1'b0);
    step(4'h5, rand_vec(), 1'b0, 1'b0);
    chk("preflush_count", 64'(count), 64'h3);
    step('0, '0, 1'b0, 1'b1);
    chk("flush_count", 64'(count), 64'h0);
    chk("flush_valid", 64'(out_valid), 64'h0);
    chk("flush_ready", 64'(lane_ready), 64'hF);
    step(4'hF, rand_vec(), 1'b1, 1'b0);
    repeat (3) step('0, '0, 1'b1, 1'b0);

    // Asynchronous reset mid-operation
    step(4'hF, rand_vec(), 1'b0, 1'b0);
    step(4'hF, rand_vec(), 1'b0, 1'b0);
    step('0, '0, 1'b0, 1'b0);
    chk("prerst_count", 64'(count), 64'h2);
    #2 reset = 1'b0;
    #1;
    chk("arst_valid", 64'(out_valid), 64'h0);
    chk("arst_data", 64'(out_data), 64'h0);
    chk("arst_count", 64'(count), 64'h0);
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (3) step('0, '0, 1'b1, 1'b0);
    chk("postrst_count", 64'(count), 64'h0);
    chk("postrst_valid", 64'(out_valid), 64'h0);
    chk("postrst_ready", 64'(lane_ready), 64'hF);

    // Random traffic
    for (int k = 0; k < 400; k++) begin
      step(LANES'($urandom_range(0, 15)), rand_vec(), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 31) == 0));
    end
    // Complete any partial vector, then drain
    step(4'hF, rand_vec(), 1'b1, 1'b0);
    step(4'hF, rand_vec(), 1'b1, 1'b0);
    repeat (8) step('0, '0, 1'b1, 1'b0);
    chk("final_empty", 64'(exp_q.size()), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/simd_result_collector.md
Name: simd_result_collector

Overview:
- Sits directly downstream of the SIMD lane array and consumes the 9-bit per-lane results.
- Each lane delivers its result independently. The block captures one result per lane into an assembly slot.
- When every lane has delivered, the lanes are packed into one result vector and pushed into a small FIFO.
- The FIFO feeds writeback through a valid/ready handshake. Lanes that finish early are back-pressured per lane until the vector is complete.

Parameters:
- LANES, 4, number of SIMD lanes collected per vector.
- RES_W, 9, width of one lane result; bit RES_W-1 is the carry/borrow bit.
- DEPTH, 4, number of FIFO entries (power of two, >=2).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous clear of assembly slots and FIFO.
- lane_valid  input  LANES  lane i presents a result this cycle.
- lane_result  input  LANES*RES_W  lane i result at bits [i*RES_W +: RES_W].
- lane_ready  output  LANES  lane i result is accepted this cycle.
- out_valid  output  1  FIFO head holds a valid vector.
- out_ready  input  1  downstream accepts the head vector.
- out_data  output  LANES*RES_W  packed head vector, same lane layout as lane_result.
- out_carry  output  LANES  out_carry[i] = bit RES_W-1 of lane i in the head vector.
- count  output  $clog2(DEPTH+1)  number of occupied FIFO entries.

Behaviour:
- Reset (reset=0, asynchronous): all assembly slots empty, FIFO pointers 0, count 0, FIFO storage 0.
- Reset outputs: out_valid=0, out_data=0, out_carry=0, lane_ready all 1. These take effect immediately, with no clock edge required.
- Capture:
  - Slot i holds captured[i] and data[i].
  - Lane i is accepted when lane_valid[i] && lane_ready[i]. data[i] loads and captured[i] sets at that edge.
  - Once captured, the slot holds its value; later lane data is ignored until the slot is released.
- pop = out_valid && out_ready.
- push = (&captured) && (count<DEPTH || pop).
  - On push, the packed slots are written at the tail and all captured bits clear.
- lane_ready[i] = !captured[i] || push.
  - In a push cycle, new results are captured into the freed slots at the same edge. Sustained throughput is one vector per cycle.
- Latency:
  - Last lane accepted at edge k: push at edge k+1, and out_valid=1 after edge k+1.
  - Pop at edge m: the next head is visible after edge m.
- FIFO is first-word-fall-through: out_data shows the head entry combinationally; out_valid = (count!=0).
- Pointers wrap modulo DEPTH.
- count updates:
  - push only: count+1.
  - pop only: count-1.
  - push and pop in the same cycle: count unchanged; allowed when full and when count=1.
- Full (count=DEPTH, no pop): push is blocked, and lanes already captured keep lane_ready=0. No data is lost or overwritten.
- Empty: out_valid=0, out_data shows the stale head storage; pop is impossible.
- Ordering: vectors leave in the order they were completed. Lane values are never mixed across vectors.
- flush=1:
  - At the next edge, all captured bits clear, both pointers reset to 0 and count becomes 0.
  - flush overrides push, pop and capture in that cycle.
  - out_valid=0 from the following cycle.
- Reset asserted mid-operation: partial vectors and FIFO contents are discarded with no further output.
- No arithmetic on data: results pass through bit-exact. The carry bit is reported, not interpreted.

Test Plan:
- Basic capture and packing: all four lanes valid in one cycle with results 0x005, 0x1FF, 0x0A0, 0x100 and out_ready=0.
  - out_valid=1 two edges later.
  - out_data = {0x100, 0x0A0, 0x1FF, 0x005}, out_carry=4'b1010, count=1.
- Staggered lanes and per-lane hold:
  - Lane0 sends 0x011 at cycle 1, then 0x022 at cycle 2.
  - Lanes 1-3 send 0x033 at cycle 4.
  - lane_ready[0]=0 during cycles 2-4. The vector holds lane0=0x011; 0x022 is not accepted.
- Full FIFO: out_ready=0 while five complete vectors are offered.
  - count saturates at 4 and lane_ready=4'b0000 for the fifth vector.
  - One cycle with out_ready=1 pops vector 1 and pushes vector 5 at the same edge; count stays 4.
- Streaming: out_ready=1 and all lanes valid every cycle with incrementing values 0,1,2,...
  - After a 2-cycle fill, one vector pops per cycle.
  - Order is preserved and count stays at 1.
- Flush: with count=3 and lanes 0 and 2 captured, pulse flush for one cycle.
  - Next cycle: count=0, out_valid=0, lane_ready=4'b1111.
  - A new full vector emerges normally afterwards.
- Asynchronous reset: with count=2, drive reset low between clock edges.
  - out_valid=0, out_data=0 and count=0 immediately.
  - State stays cleared after release until new lane input arrives.
